// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 16;
    localparam int FETCH_INSTR_W = 16;

    localparam logic [FETCH_ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [FETCH_ADDR_W-1:0] PC_STEP  = 16'd2;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - two-entry FIFO of fetched {instr, pc} pairs with synchronous flush
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An empty queue presents zeros so decode never sees stale entries.
    assign o_count = r_count;
    assign o_head  = (r_count == 2'd0) ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch issue/redirect control feeding decode
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [ADDR_W-1:0] PC_STEP  = fetch_pkg::PC_STEP
)(
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;

    logic [1:0]   w_count;
    logic [2:0]   w_occ;
    logic         w_pop;
    logic         w_push;
    logic         w_issue;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;

    // Occupancy after this cycle's pop decides whether one more fetch still fits.
    assign out_valid    = (w_count != 2'd0);
    assign w_pop        = out_valid && out_ready;
    assign w_occ        = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = !redirect_valid && (w_occ < 3'd2);
    assign w_push       = r_inflight && !redirect_valid;
    assign w_push_entry = '{instr: imem_data, pc: r_inflight_pc};

    assign imem_addr = r_pc;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[ADDR_W-1:1], 1'b0};
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= r_pc + PC_STEP;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_queue u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;

    int          n_tests;
    int          n_fail;
    int          n_accept;
    logic        sb_en;
    logic [15:0] exp_pc;
    logic        prev_stall;
    logic [15:0] prev_pc;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    always @(posedge clk) imem_data <= mem_f(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program-order scoreboard: each accepted instruction must be the next PC in
    // the architectural stream, and a presented instruction must hold until taken.
    always @(negedge clk) begin
        if (!rst_n || !sb_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_pc", {16'd0, out_pc}, {16'd0, prev_pc});
            end
            if (out_valid && out_ready) begin
                check("sb_pc", {16'd0, out_pc}, {16'd0, exp_pc});
                check("sb_instr", {16'd0, out_instr}, {16'd0, mem_f(exp_pc)});
                n_accept++;
            end
            if (redirect_valid)
                exp_pc = {redirect_pc[15:1], 1'b0};
            else if (out_valid && out_ready)
                exp_pc = exp_pc + 16'd2;
            prev_stall = out_valid && !out_ready && !redirect_valid;
            prev_pc    = out_pc;
        end
    end

    task automatic do_redirect(input logic [15:0] tgt);
        logic [15:0] t;
        t = {tgt[15:1], 1'b0};
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 16'($urandom);
        out_ready      = 1'b1;
        check("redir_addr", {16'd0, imem_addr}, {16'd0, t});
        check("redir_v1", {31'd0, out_valid}, 32'd0);
        step();
        check("redir_v2", {31'd0, out_valid}, 32'd0);
        step();
        check("redir_v3", {31'd0, out_valid}, 32'd1);
        check("redir_pc", {16'd0, out_pc}, {16'd0, t});
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_accept = 0;
        sb_en = 1'b0; exp_pc = 16'h0000; prev_stall = 1'b0; prev_pc = 16'h0000;
        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        repeat (2) step();
        check("rst_addr", {16'd0, imem_addr}, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", {16'd0, out_instr}, 32'h0);
        check("rst_pc", {16'd0, out_pc}, 32'h0);

        rst_n = 1'b1;
        sb_en = 1'b1;
        check("c0_addr", {16'd0, imem_addr}, 32'h0);
        check("c0_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("c1_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("c2_valid", {31'd0, out_valid}, 32'd1);
        check("c2_pc", {16'd0, out_pc}, 32'h0);
        check("c2_instr", {16'd0, out_instr}, {16'd0, mem_f(16'h0000)});
        step();
        check("c3_pc", {16'd0, out_pc}, 32'h2);

        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check("stall_pc", {16'd0, out_pc}, 32'h2);
            if (i > 0) check("stall_addr", {16'd0, imem_addr}, 32'h6);
        end
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("resume_pc", {16'd0, out_pc}, 32'(2 + 2 * k));
            check("resume_valid", {31'd0, out_valid}, 32'd1);
            step();
        end

        out_ready = 1'b0;
        repeat (4) step();
        do_redirect(16'h0010);
        repeat (3) step();
        do_redirect(16'h0013);
        step();
        check("odd_next", {16'd0, out_pc}, 32'h0014);
        do_redirect(16'hFFFC);
        step();
        check("wrap_1", {16'd0, out_pc}, 32'hFFFE);
        step();
        check("wrap_2", {16'd0, out_pc}, 32'h0000);
        step();
        check("wrap_3", {16'd0, out_pc}, 32'h0002);

        for (int n = 0; n < 400; n++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 16'($urandom);
            step();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("accept_count", {31'd0, (n_accept > 150)}, 32'd1);

        repeat (3) step();
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        exp_pc = 16'h0000;
        #1;
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_addr", {16'd0, imem_addr}, 32'h0);
        step();
        rst_n = 1'b1;
        check("mrst_c0_addr", {16'd0, imem_addr}, 32'h0);
        step();
        check("mrst_c1_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("mrst_c2_valid", {31'd0, out_valid}, 32'd1);
        check("mrst_c2_pc", {16'd0, out_pc}, 32'h0);
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
